// File: rtl/uart_tx.sv
// uart_tx: AXI-Stream byte in, 8-bit UART frame out on o_txd.
// Start bit, LSB-first data, optional parity, 1 or 2 stop bits.
module uart_tx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_s_axis_tvalid,
  input  logic [7:0] i_s_axis_tdata,
  output logic       o_s_axis_tready,
  output logic       o_txd,
  output logic       o_busy
);

  localparam logic [15:0] C_LAST = 16'(CLKS_PER_BIT - 1);
  localparam bit PAR_EN  = (PARITY == 1) || (PARITY == 2);
  localparam bit PAR_ODD = (PARITY == 1);
  localparam logic [2:0] STOP_LAST = (STOP_BITS == 2) ? 3'd1 : 3'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t      r_state;
  logic [15:0] r_clk_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        r_par;
  logic        r_txd;
  logic        r_tready;
  logic        r_busy;
  logic        w_bit_done;

  assign w_bit_done      = (r_clk_cnt == C_LAST);
  assign o_txd           = r_txd;
  assign o_s_axis_tready = r_tready;
  assign o_busy          = r_busy;

  // Frame sequencer: state, bit timing and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_txd     <= 1'b1;
      r_tready  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_txd     <= 1'b1;
          r_tready  <= 1'b1;
          r_clk_cnt <= '0;
          r_bit_cnt <= '0;
          if (i_s_axis_tvalid && r_tready) begin
            r_shift  <= i_s_axis_tdata;
            r_par    <= PAR_ODD ? ~^i_s_axis_tdata
                                :  ^i_s_axis_tdata;
            r_tready <= 1'b0;
            r_busy   <= 1'b1;
            r_txd    <= 1'b0;
            r_state  <= S_START;
          end
        end
        S_START: begin
          if (w_bit_done) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_txd     <= r_shift[0];
            r_state   <= S_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (w_bit_done) begin
            r_clk_cnt <= '0;
            if (r_bit_cnt == 3'd7) begin
              r_bit_cnt <= '0;
              if (PAR_EN) begin
                r_txd   <= r_par;
                r_state <= S_PARITY;
              end else begin
                r_txd   <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_shift   <= r_shift >> 1;
              r_txd     <= r_shift[1];
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end
        S_PARITY: begin
          if (w_bit_done) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_txd     <= 1'b1;
            r_state   <= S_STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end
        S_STOP: begin
          r_txd <= 1'b1;
          if (w_bit_done) begin
            r_clk_cnt <= '0;
            if (r_bit_cnt == STOP_LAST) begin
              r_bit_cnt <= '0;
              r_tready  <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= S_IDLE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_clk_cnt <= '0;
          r_bit_cnt <= '0;
          r_txd     <= 1'b1;
          r_tready  <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed frame vectors on three parameterisations.
// u0: no parity/1 stop, u1: even/2 stop, u2: odd/1 stop; CLKS_PER_BIT=4.
module tb_uart_tx;

  localparam int CPB = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [2:0]      vld = '0;
  logic [2:0][7:0] dat = '0;
  logic [2:0]      txd;
  logic [2:0]      busy;
  logic [2:0]      rdy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u0 (
    .i_clk(clk), .i_rst(rst),
    .i_s_axis_tvalid(vld[0]), .i_s_axis_tdata(dat[0]),
    .o_s_axis_tready(rdy[0]), .o_txd(txd[0]), .o_busy(busy[0])
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(2)) u1 (
    .i_clk(clk), .i_rst(rst),
    .i_s_axis_tvalid(vld[1]), .i_s_axis_tdata(dat[1]),
    .o_s_axis_tready(rdy[1]), .o_txd(txd[1]), .o_busy(busy[1])
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) u2 (
    .i_clk(clk), .i_rst(rst),
    .i_s_axis_tvalid(vld[2]), .i_s_axis_tdata(dat[2]),
    .o_s_axis_tready(rdy[2]), .o_txd(txd[2]), .o_busy(busy[2])
  );

  typedef struct {
    int          s;
    logic [7:0]  d;
    int          nb;
    logic [11:0] ex;
    string       nm;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b want=%b", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  // One full frame: handshake, per-bit/per-cycle line check, end state.
  task automatic run_frame(input int s, input logic [7:0] d,
                           input int nb, input logic [11:0] ex,
                           input string nm);
    logic bad;
    logic bt, bb, br;
    @(negedge clk);
    chk({nm, "_rdy_pre"}, rdy[s], 1'b1);
    vld[s] = 1'b1;
    dat[s] = d;
    @(negedge clk);
    vld[s] = 1'b0;
    dat[s] = ~d;
    for (int b = 0; b < nb; b++) begin
      bad = 1'b0;
      bt = 1'b0; bb = 1'b0; br = 1'b0;
      for (int c = 0; c < CPB; c++) begin
        if (txd[s] !== ex[b] || busy[s] !== 1'b1 ||
            rdy[s] !== 1'b0) begin
          bad = 1'b1;
          bt = txd[s]; bb = busy[s]; br = rdy[s];
        end
        if (b == 4 && c == 0) vld[s] = 1'b1;
        if (b == 5 && c == 0) vld[s] = 1'b0;
        @(negedge clk);
      end
      n_chk++;
      if (bad) begin
        n_fail++;
        $display("FAIL %s bit%0d txd=%b busy=%b rdy=%b want txd=%b busy=1 rdy=0",
                 nm, b, bt, bb, br, ex[b]);
      end
    end
    chk({nm, "_busy_end"}, busy[s], 1'b0);
    chk({nm, "_rdy_end"}, rdy[s], 1'b1);
    chk({nm, "_txd_end"}, txd[s], 1'b1);
  endtask

  logic       tr [200];
  logic [7:0] bb3 [3];
  int         st [4];
  logic [7:0] got [4];
  int         nst;
  int         idx;
  logic       pend;
  logic       quiet;

  initial begin
    vecs[0] = '{0, 8'h55, 10, 12'h2AA, "u0_55"};
    vecs[1] = '{0, 8'hA3, 10, 12'h346, "u0_A3"};
    vecs[2] = '{0, 8'hFF, 10, 12'h3FE, "u0_FF"};
    vecs[3] = '{1, 8'h07, 12, 12'hE0E, "even2_07"};
    vecs[4] = '{1, 8'h00, 12, 12'hC00, "even2_00"};
    vecs[5] = '{1, 8'hA3, 12, 12'hD46, "even2_A3"};
    vecs[6] = '{2, 8'h07, 11, 12'h40E, "odd_07"};
    vecs[7] = '{2, 8'h00, 11, 12'h600, "odd_00"};

    // reset state
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("rst_txd%0d", s), txd[s], 1'b1);
      chk($sformatf("rst_rdy%0d", s), rdy[s], 1'b0);
      chk($sformatf("rst_busy%0d", s), busy[s], 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++)
      chk($sformatf("rel_rdy%0d", s), rdy[s], 1'b1);

    // table-driven frames
    for (int i = 0; i < 8; i++)
      run_frame(vecs[i].s, vecs[i].d, vecs[i].nb, vecs[i].ex, vecs[i].nm);

    // back-to-back with tvalid held high
    bb3[0] = 8'h00;
    bb3[1] = 8'hFF;
    bb3[2] = 8'h3C;
    @(negedge clk);
    vld[0] = 1'b1;
    dat[0] = bb3[0];
    idx = 0;
    pend = 1'b0;
    for (int k = 0; k < 160; k++) begin
      tr[k] = txd[0];
      if (pend) begin
        idx++;
        if (idx < 3) dat[0] = bb3[idx];
        else vld[0] = 1'b0;
      end
      pend = vld[0] & rdy[0];
      @(negedge clk);
    end
    nst = 0;
    begin
      int i;
      i = 1;
      while (i < 120) begin
        if (tr[i-1] && !tr[i] && nst < 4) begin
          st[nst] = i;
          for (int k = 0; k < 8; k++)
            got[nst][k] = tr[i + 6 + 4 * k];
          nst++;
          i += 39;
        end else begin
          i++;
        end
      end
    end
    chk_int("b2b_frames", nst, 3);
    if (nst >= 3) begin
      chk_int("b2b_byte0", int'(got[0]), 8'h00);
      chk_int("b2b_byte1", int'(got[1]), 8'hFF);
      chk_int("b2b_byte2", int'(got[2]), 8'h3C);
      chk_int("b2b_gap01", st[1] - st[0], 41);
      chk_int("b2b_gap12", st[2] - st[1], 41);
    end

    // tvalid during reset, dropped before tready: nothing sent
    rst = 1'b1;
    vld[0] = 1'b1;
    dat[0] = 8'h99;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    vld[0] = 1'b0;
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (txd[0] !== 1'b1 || busy[0] !== 1'b0) quiet = 1'b0;
    end
    chk("drop_vld_quiet", quiet, 1'b1);
    chk("drop_vld_rdy", rdy[0], 1'b1);

    // reset during data bit 3 of 0x81
    vld[0] = 1'b1;
    dat[0] = 8'h81;
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (17) @(negedge clk);
    chk("mid_busy", busy[0], 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_txd", txd[0], 1'b1);
    chk("mid_rst_rdy", rdy[0], 1'b0);
    chk("mid_rst_busy", busy[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rel_rdy", rdy[0], 1'b1);
    chk("mid_rel_txd", txd[0], 1'b1);
    run_frame(0, 8'h42, 10, 12'h284, "after_rst_42");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
